// File: rtl/dsp_mux_drv.sv
// Multiplexed N-digit 7-segment driver with an internal scan prescaler, PWM dimming,
// anti-ghosting dead time and frame-synchronous shadowing of the digit data.
module dsp_mux_drv #(
  parameter int unsigned DIGITS      = 8,
  parameter int unsigned SCAN_DIV    = 12500,
  parameter int unsigned DEAD        = 2,
  parameter int unsigned BRIGHT_W    = 4,
  parameter int unsigned AN_ACT_LOW  = 0,
  parameter int unsigned SEG_ACT_LOW = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [8*DIGITS-1:0]   d,
  input  logic [DIGITS-1:0]     blank,
  input  logic [BRIGHT_W-1:0]   bright,
  input  logic                  en,
  output logic [DIGITS-1:0]     an,
  output logic [7:0]            seg,
  output logic                  frame_start
);

  localparam int unsigned IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int unsigned PRE_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  localparam logic [PRE_W-1:0]  PRE_LAST = PRE_W'(SCAN_DIV - 1);
  localparam logic [PRE_W-1:0]  DEAD_END = PRE_W'(DEAD);
  localparam logic [IDX_W-1:0]  IDX_LAST = IDX_W'(DIGITS - 1);
  localparam logic [DIGITS-1:0] AN_OFF   = (AN_ACT_LOW != 0) ? {DIGITS{1'b1}} : {DIGITS{1'b0}};
  localparam logic [7:0]        SEG_OFF  = (SEG_ACT_LOW != 0) ? 8'hFF : 8'h00;

  logic [PRE_W-1:0]    pre;
  logic [IDX_W-1:0]    idx;
  logic [BRIGHT_W-1:0] pw;
  logic [8*DIGITS-1:0] d_sh;
  logic [DIGITS-1:0]   blank_sh;
  logic [BRIGHT_W-1:0] bright_sh;

  logic                tick_c;
  logic                wrap_c;
  logic [7:0]          digit_c;
  logic [DIGITS-1:0]   onehot_c;
  logic                blank_c;
  logic                pwm_on_c;
  logic                act_c;

  assign tick_c = (pre == PRE_LAST);
  assign wrap_c = tick_c && (idx == IDX_LAST);

  // Slot prescaler and digit index
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre <= '0;
      idx <= '0;
    end else begin
      if (tick_c) begin
        pre <= '0;
        idx <= (idx == IDX_LAST) ? '0 : idx + IDX_W'(1);
      end else begin
        pre <= pre + PRE_W'(1);
      end
    end
  end

  // Free-running PWM phase counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pw <= '0;
    end else begin
      pw <= pw + BRIGHT_W'(1);
    end
  end

  // Shadow copies only change at the frame boundary so a frame never tears
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      d_sh        <= '0;
      blank_sh    <= '0;
      bright_sh   <= '0;
      frame_start <= 1'b0;
    end else begin
      frame_start <= wrap_c;
      if (wrap_c) begin
        d_sh      <= d;
        blank_sh  <= blank;
        bright_sh <= bright;
      end
    end
  end

  // Per-digit selection with constant indices only
  always_comb begin
    digit_c  = '0;
    onehot_c = '0;
    blank_c  = 1'b0;
    for (int i = 0; i < int'(DIGITS); i++) begin
      if (idx == IDX_W'(i)) begin
        digit_c     = d_sh[8*i +: 8];
        onehot_c[i] = 1'b1;
        blank_c     = blank_sh[i];
      end
    end
  end

  assign pwm_on_c = (bright_sh == {BRIGHT_W{1'b1}}) || (pw < bright_sh);
  assign act_c    = en && !blank_c && pwm_on_c && (pre >= DEAD_END);

  // Pin drivers, polarity folded into the register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      an  <= AN_OFF;
      seg <= SEG_OFF;
    end else begin
      an  <= act_c ? (onehot_c ^ AN_OFF) : AN_OFF;
      seg <= act_c ? (digit_c ^ SEG_OFF) : SEG_OFF;
    end
  end

endmodule
